// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: streams a program image into instruction memory, then releases the core at RESET_PC
// Ports: clk/rst_n clock and async active-low reset; boot_req (re)load request pulse;
//   ld_valid/ld_data/ld_last/ld_ready loader stream; imem_we/imem_waddr/imem_wdata memory write port;
//   cpu_hold/pc_load/pc_load_val core control; boot_done/load_count/err_overflow status.
module imem_boot_ctrl #(
    parameter int          AW       = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_req,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          pc_load,
    output logic [31:0]   pc_load_val,
    output logic          boot_done,
    output logic [AW:0]   load_count,
    output logic          err_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
    state_t state, state_nx;
    logic xfer, start;
    assign pc_load_val = RESET_PC;
    assign xfer  = (state == LOAD) && ld_valid;
    assign start = boot_req && (state == IDLE || state == RUN);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        cpu_hold = 1'b1;
        pc_load  = 1'b0;
        boot_done = 1'b0;
        case (state)
            IDLE:    state_nx = boot_req ? LOAD : IDLE;
            LOAD: begin
                ld_ready = 1'b1;
                state_nx = (ld_valid && ld_last) ? RELEASE : LOAD;
            end
            RELEASE: begin
                pc_load  = 1'b1;
                state_nx = RUN;
            end
            default: begin
                cpu_hold  = 1'b0;
                boot_done = 1'b1;
                state_nx  = boot_req ? LOAD : RUN;
            end
        endcase
    end
    // Writes are registered, so each accepted word reaches memory one cycle later;
    // load_count[AW] set means the memory is full and further words are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            load_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                load_count   <= '0;
                err_overflow <= 1'b0;
            end else if (xfer) begin
                if (!load_count[AW]) begin
                    imem_we    <= 1'b1;
                    imem_waddr <= load_count[AW-1:0];
                    imem_wdata <= ld_data;
                    load_count <= load_count + 1'b1;
                end else begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end
endmodule
